// File: rtl/sv_if_arbiter_pkg.sv
// Shared types and helpers for the round-robin sv_if channel arbiter.
package sv_if_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BURST = 1'b1} arb_state_t;

  // OR-reduction of set-bit positions; exact for one-hot, zero for no bits set.
  function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sv_if_arbiter_if.sv
// Requester-side and sv_if-side signals of the arbiter bundled into one interface.
interface sv_if_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_ready;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;

  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_data, grant, busy
  );

  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_data, grant, busy
  );
endinterface

// File: rtl/sv_if_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       found
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sv_if_arbiter.sv
// Round-robin arbiter: one burst per grant, beats forwarded through a single output register.
module sv_if_arbiter
  import sv_if_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sv_if_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic                pick_found;
  logic [IDX_W-1:0]    g_idx;
  logic [IDX_W-1:0]    next_ptr;
  logic [NUM_REQ-1:0]  req_ready_w;
  logic [DATA_W-1:0]   beat;
  logic                out_accept;
  logic                xfer_in;
  logic                end_burst;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .found (pick_found)
  );

  assign g_idx       = IDX_W'(onehot2idx(16'(grant_q)));
  assign next_ptr    = (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
  // The output register can take a new beat when empty or draining this cycle.
  assign out_accept  = !out_valid_q || bus.out_ready;
  assign req_ready_w = (state_q == ARB_BURST && out_accept) ? grant_q : '0;
  assign xfer_in     = |(bus.req_valid & req_ready_w);
  assign beat        = bus.req_data[int'(g_idx)*DATA_W +: DATA_W];
  assign end_burst   = xfer_in && (bus.req_last[g_idx] || beat_cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d    = pick_gnt;
          beat_cnt_d = '0;
          state_d    = ARB_BURST;
        end
      end
      default: begin
        if (xfer_in) beat_cnt_d = beat_cnt_q + 1'b1;
        if (end_burst) begin
          rr_ptr_d = next_ptr;
          grant_d  = '0;
          state_d  = ARB_IDLE;
        end
      end
    endcase

    if (xfer_in) begin
      out_valid_d = 1'b1;
      out_data_d  = beat;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.req_ready = req_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == ARB_BURST);
endmodule

// File: tb/tb_sv_if_arbiter.sv
// Self-checking bench for sv_if_arbiter: vector table plus queue-driven burst scenarios.
module tb_sv_if_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic clk;
  logic rst_n;

  sv_if_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  sv_if_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  last;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  e_grant;
    logic        e_busy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [3:0]  e_rdy;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } beat_t;

  int         checks;
  int         failures;
  beat_t      src_q [NR][$];
  int         gap_cnt [NR];
  logic [7:0] exp_q [$];
  int         glog [$];
  int         gcyc [$];
  logic [3:0] prev_grant;
  logic [3:0] hs;
  int         cyc;
  vec_t       vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, expv, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0 && gap_cnt[i] == 0) begin
        bus.req_valid[i]         = 1'b1;
        bus.req_last[i]          = src_q[i][0].last;
        bus.req_data[i*DW +: DW] = src_q[i][0].data;
      end else begin
        bus.req_valid[i]         = 1'b0;
        bus.req_last[i]          = 1'b0;
        bus.req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic enq(input int i, input logic [7:0] d, input logic l, input int gap);
    beat_t b;
    b.data = d;
    b.last = l;
    b.gap  = gap;
    if (src_q[i].size() == 0) gap_cnt[i] = gap;
    src_q[i].push_back(b);
  endtask

  task automatic sample();
    int gi;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NR; i++) hs[i] = bus.req_valid[i] & bus.req_ready[i];
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%h expected=none", bus.out_data);
      end else begin
        chk("sb_data", {24'h0, bus.out_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (bus.grant != 4'b0000 && prev_grant == 4'b0000) begin
      gi = -1;
      for (int i = 0; i < NR; i++) if (bus.grant[i]) gi = i;
      glog.push_back(gi);
      gcyc.push_back(cyc);
    end
    prev_grant = bus.grant;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) gap_cnt[i] = src_q[i][0].gap;
      end else if (gap_cnt[i] > 0) begin
        gap_cnt[i]--;
      end
    end
    refresh();
  endtask

  function automatic int pending();
    int n;
    n = exp_q.size();
    for (int i = 0; i < NR; i++) n += src_q[i].size();
    if (bus.out_valid) n++;
    return n;
  endfunction

  task automatic run(input int budget, input bit gap_chk);
    int n;
    n = 0;
    while (pending() != 0 && n < budget) begin
      sample();
      if (gap_chk && gap_cnt[0] > 0 && bus.busy) chk("gap_hold", {28'h0, bus.grant}, 32'h1);
      advance();
      n++;
    end
    chk("drain", pending(), 0);
  endtask

  task automatic chk_glog(input int eg [$]);
    chk("glog_len", glog.size(), eg.size());
    for (int k = 0; k < eg.size(); k++) begin
      if (k < glog.size()) chk("glog", glog[k], eg[k]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      gap_cnt[i] = 0;
    end
    exp_q.delete();
    glog.delete();
    gcyc.delete();
    hs = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    prev_grant = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int eg [$];
    logic [7:0] held;
    checks   = 0;
    failures = 0;
    cyc      = 0;

    // Single requester: req1 sends A,B,C (last on C), cycle-exact.
    vt[0] = '{4'b0010, 4'b0000, 32'h0000_A100, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    vt[1] = '{4'b0010, 4'b0000, 32'h0000_A100, 1'b1, 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0010};
    vt[2] = '{4'b0010, 4'b0000, 32'h0000_B200, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA1, 4'b0010};
    vt[3] = '{4'b0010, 4'b0010, 32'h0000_C300, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hB2, 4'b0010};
    vt[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 1'b1, 8'hC3, 4'b0000};
    vt[5] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'hC3, 4'b0000};

    do_reset();
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = vt[k].v;
      bus.req_last  = vt[k].last;
      bus.req_data  = vt[k].data;
      bus.out_ready = vt[k].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_grant", k), {28'h0, bus.grant}, {28'h0, vt[k].e_grant});
      chk($sformatf("v%0d_busy", k), {31'h0, bus.busy}, {31'h0, vt[k].e_busy});
      chk($sformatf("v%0d_ovalid", k), {31'h0, bus.out_valid}, {31'h0, vt[k].e_ov});
      chk($sformatf("v%0d_odata", k), {24'h0, bus.out_data}, {24'h0, vt[k].e_od});
      chk($sformatf("v%0d_rready", k), {28'h0, bus.req_ready}, {28'h0, vt[k].e_rdy});
      @(posedge clk);
      #1;
    end

    // Reset mid-burst clears outputs at once; afterwards req0 wins.
    do_reset();
    bus.req_valid = 4'b1100;
    bus.req_data  = 32'h5A5A_0000;
    @(posedge clk);
    #1 chk("rst_pre_grant", {28'h0, bus.grant}, 32'h4);
    @(posedge clk);
    @(negedge clk);
    chk("rst_pre_ovalid", {31'h0, bus.out_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_grant", {28'h0, bus.grant}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_ovalid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_odata", {24'h0, bus.out_data}, 32'h0);
    chk("rst_rready", {28'h0, bus.req_ready}, 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b1101;
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_first_grant", {28'h0, bus.grant}, 32'h1);

    // Round robin with continuous single-beat bursts.
    do_reset();
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < NR; i++) begin
        enq(i, 8'(i*16 + j), 1'b1, 0);
        exp_q.push_back(8'(i*16 + j));
      end
    end
    refresh();
    run(100, 1'b0);
    eg = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_glog(eg);
    for (int k = 1; k < gcyc.size(); k++) chk("rr_spacing", gcyc[k] - gcyc[k-1], 2);

    // Burst cap, lone requester: regranted for the tail.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      enq(2, 8'(8'h20 + k), k == 5, 0);
      exp_q.push_back(8'(8'h20 + k));
    end
    refresh();
    run(100, 1'b0);
    eg = '{2, 2};
    chk_glog(eg);
    if (gcyc.size() >= 2) chk("cap_spacing", gcyc[1] - gcyc[0], 5);

    // Burst cap with another requester pending: it is served before the tail.
    do_reset();
    for (int k = 0; k < 6; k++) enq(2, 8'(8'h20 + k), k == 5, 0);
    enq(3, 8'h3F, 1'b1, 0);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h20 + k));
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'h24);
    exp_q.push_back(8'h25);
    refresh();
    run(100, 1'b0);
    eg = '{2, 3, 2};
    chk_glog(eg);

    // Backpressure for 3 cycles mid-burst.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      enq(1, 8'(8'h50 + k), k == 5, 0);
      exp_q.push_back(8'(8'h50 + k));
    end
    refresh();
    held = '0;
    for (int n = 0; n < 100 && pending() != 0; n++) begin
      sample();
      if (n == 3) begin
        held = bus.out_data;
        chk("bp_first", {24'h0, bus.out_data}, 32'h51);
      end
      if (n >= 3 && n <= 5) begin
        chk("bp_rready", {28'h0, bus.req_ready}, 32'h0);
        chk("bp_ovalid", {31'h0, bus.out_valid}, 32'h1);
      end
      if (n == 4 || n == 5) chk("bp_hold", {24'h0, bus.out_data}, {24'h0, held});
      advance();
      bus.out_ready = !((n + 1) >= 3 && (n + 1) <= 5);
    end
    chk("bp_drain", pending(), 0);

    // Valid gap mid-burst: grant held, req1 waits.
    do_reset();
    enq(0, 8'h01, 1'b0, 0);
    enq(0, 8'h02, 1'b0, 2);
    enq(0, 8'h03, 1'b1, 0);
    enq(1, 8'h11, 1'b1, 0);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h11);
    refresh();
    run(100, 1'b1);
    eg = '{0, 1};
    chk_glog(eg);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
